// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC channel: FSM state encoding,
// fine-code width helper and the minimum dead time.
package tdc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DEAD    = 2'd3
    } tdc_state_t;

    localparam int TDC_DEAD_MIN = 1;

    // Width that holds every fine code 0..num_taps inclusive
    function automatic int fine_w(input int num_taps);
        return $clog2(num_taps + 1);
    endfunction

endpackage

// File: rtl/tdc_channel_if.sv
// Timestamp bus between one TDC channel (master) and its readout logic (slave).
interface tdc_channel_if
    import tdc_pkg::*;
#(
    parameter int NUM_TAPS = 64,
    parameter int COARSE_W = 16
);
    localparam int FINE_W = fine_w(NUM_TAPS);

    logic                enable;
    logic                ts_valid;
    logic [COARSE_W-1:0] ts_coarse;
    logic [FINE_W-1:0]   ts_fine;
    logic                ts_sat;
    logic                ovf;
    logic                busy;

    modport master (
        input  enable,
        output ts_valid, ts_coarse, ts_fine, ts_sat, ovf, busy
    );

    modport slave (
        output enable,
        input  ts_valid, ts_coarse, ts_fine, ts_sat, ovf, busy
    );

endinterface

// File: rtl/tdc_delay_line.sv
// CARRY4-style carry chain: NUM_TAPS/4 cells, hit launched through CYINIT,
// every carry-out is a tap. Hierarchy is kept so placement constraints stick.
(* keep_hierarchy = "yes", dont_touch = "true" *)
module tdc_delay_line #(
    parameter int NUM_TAPS = 64
) (
    input  logic                hit,
    output logic [NUM_TAPS-1:0] taps
);
    localparam int         CELLS    = NUM_TAPS / 4;
    localparam logic [3:0] CARRY_S  = 4'b1111;
    localparam logic [3:0] CARRY_DI = 4'b0000;
    localparam logic       CARRY_CI = 1'b0;

    (* dont_touch = "true" *) logic [NUM_TAPS:0] chain;

    // CI of the first cell is tied low, so only CYINIT (the hit) starts the carry
    assign chain[0] = CARRY_CI | hit;

    for (genvar c = 0; c < CELLS; c++) begin : g_cell
        for (genvar b = 0; b < 4; b++) begin : g_bit
            assign chain[4*c+b+1] = CARRY_S[b] ? chain[4*c+b] : CARRY_DI[b];
        end
    end

    assign taps = chain[NUM_TAPS:1];

endmodule

// File: rtl/tdc_channel.sv
// Single TDC channel: delay-line sampling, thermometer decode, edge detect,
// dead time and coarse counter. Optional macro: TDC_BUBBLE_FILTER_EN.
module tdc_channel
    import tdc_pkg::*;
#(
    parameter int NUM_TAPS    = 64,
    parameter int COARSE_W    = 16,
    parameter int DEAD_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hit,
    tdc_channel_if.master bus
);
    localparam int FINE_W   = fine_w(NUM_TAPS);
    localparam int DEAD_LEN = (DEAD_CYCLES < TDC_DEAD_MIN) ? TDC_DEAD_MIN : DEAD_CYCLES;
    localparam int DEAD_W   = $clog2(DEAD_LEN + 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_LEN - 1);

    function automatic logic [FINE_W-1:0] popcount(input logic [NUM_TAPS-1:0] t);
        logic [FINE_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            n = n + FINE_W'(t[i]);
        end
        return n;
    endfunction

`ifdef TDC_BUBBLE_FILTER_EN
    // Three-tap majority vote; the line is assumed set below tap 0 and clear above the top
    function automatic logic [NUM_TAPS-1:0] bubble_filter(input logic [NUM_TAPS-1:0] t);
        logic [NUM_TAPS+1:0] ext;
        logic [NUM_TAPS-1:0] res;
        ext = {1'b0, t, 1'b1};
        for (int i = 0; i < NUM_TAPS; i++) begin
            res[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
        end
        return res;
    endfunction
`endif

    logic [NUM_TAPS-1:0] taps;
    (* ASYNC_REG = "TRUE" *) logic [NUM_TAPS-1:0] s1_p0;
    (* ASYNC_REG = "TRUE" *) logic [NUM_TAPS-1:0] s2_p1;
    logic                s2_prev;
    logic [NUM_TAPS-1:0] therm;
    logic [FINE_W-1:0]   fine;
    logic                hit_edge;

    logic [COARSE_W-1:0] cnt;
    logic [COARSE_W-1:0] cnt_p0;
    logic [COARSE_W-1:0] cnt_p1;
    logic                ovf_r;

    tdc_state_t          state;
    logic [DEAD_W-1:0]   dead_cnt;
    logic                ts_valid_r;
    logic [COARSE_W-1:0] ts_coarse_r;
    logic [FINE_W-1:0]   ts_fine_r;
    logic                ts_sat_r;
    logic                busy_r;

    tdc_delay_line #(.NUM_TAPS(NUM_TAPS)) u_line (
        .hit  (hit),
        .taps (taps)
    );

    // Stage p0/p1: two-flop sampling of the taps, coarse count delayed to match
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_p0   <= '0;
            s2_p1   <= '0;
            s2_prev <= 1'b0;
            cnt     <= '0;
            cnt_p0  <= '0;
            cnt_p1  <= '0;
            ovf_r   <= 1'b0;
        end else begin
            s1_p0   <= taps;
            s2_p1   <= s1_p0;
            s2_prev <= s2_p1[0];
            cnt     <= cnt + 1'b1;
            cnt_p0  <= cnt;
            cnt_p1  <= cnt_p0;
            ovf_r   <= &cnt;
        end
    end

`ifdef TDC_BUBBLE_FILTER_EN
    assign therm = bubble_filter(s2_p1);
`else
    assign therm = s2_p1;
`endif

    assign fine     = popcount(therm);
    assign hit_edge = s2_p1[0] & ~s2_prev;

    // Stage p2: channel FSM and timestamp registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            dead_cnt    <= '0;
            ts_valid_r  <= 1'b0;
            ts_coarse_r <= '0;
            ts_fine_r   <= '0;
            ts_sat_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            ts_valid_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.enable && !s2_p1[0]) begin
                        state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (!bus.enable) begin
                        state <= ST_IDLE;
                    end else if (hit_edge) begin
                        state       <= ST_CAPTURE;
                        ts_valid_r  <= 1'b1;
                        ts_coarse_r <= cnt_p1;
                        ts_fine_r   <= fine;
                        ts_sat_r    <= &s2_p1;
                        busy_r      <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    state    <= ST_DEAD;
                    dead_cnt <= '0;
                end
                ST_DEAD: begin
                    // Stay dead until the minimum time has elapsed and the hit has gone low
                    if (dead_cnt == DEAD_LAST && !s2_p1[0]) begin
                        state  <= bus.enable ? ST_ARMED : ST_IDLE;
                        busy_r <= 1'b0;
                    end else if (dead_cnt != DEAD_LAST) begin
                        dead_cnt <= dead_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ts_valid  = ts_valid_r;
    assign bus.ts_coarse = ts_coarse_r;
    assign bus.ts_fine   = ts_fine_r;
    assign bus.ts_sat    = ts_sat_r;
    assign bus.ovf       = ovf_r;
    assign bus.busy      = busy_r;

endmodule
